// File: rtl/fixed_sqrt_if.sv
// Radicand-in / root-out bus for fixed_sqrt.
//   in_valid  : radicand-valid strobe (upstream divider result-valid)
//   in_data   : radicand, unsigned UQ10.10
//   busy      : root iteration in progress
//   out_valid : one-cycle result strobe
//   out_data  : root, unsigned UQ5.10
// master = producer of radicands / consumer of roots; slave = fixed_sqrt.
interface fixed_sqrt_if;
  logic        in_valid;
  logic [19:0] in_data;
  logic        busy;
  logic        out_valid;
  logic [14:0] out_data;

  modport master (output in_valid, output in_data,
                  input  busy, input out_valid, input out_data);
  modport slave  (input  in_valid, input in_data,
                  output busy, output out_valid, output out_data);
endinterface

// File: rtl/fixed_sqrt.sv
// Bit-serial fixed-point square root: out_data = floor(sqrt(in_data << 10)).
// One root bit is resolved per clock, MSB first, 15 clocks per result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   sq    : fixed_sqrt_if.slave (in_valid/in_data in, busy/out_valid/out_data out)
module fixed_sqrt (
  input  logic         clk,
  input  logic         rst_n,
  fixed_sqrt_if.slave  sq
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [19:0] rad_q, rad_d;
  logic [14:0] root_q, root_d;
  logic [14:0] bit_q, bit_d;
  logic [14:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic [14:0] trial;
  logic [29:0] trial_sq;
  logic        fits;

  // Full 30-bit square against the radicand scaled to UQ20.20; the largest
  // root (7FFF) squared still fits, so nothing is truncated.
  assign trial    = root_q | bit_q;
  assign trial_sq = {15'b0, trial} * {15'b0, trial};
  assign fits     = (trial_sq <= {rad_q, 10'b0});

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    root_d      = root_q;
    bit_d       = bit_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sq.in_valid) begin
          rad_d   = sq.in_data;
          root_d  = '0;
          bit_d   = 15'h4000;
          state_d = CALC;
        end
      end
      CALC: begin
        if (fits) root_d = trial;
        bit_d = bit_q >> 1;
        // Trial bit at position 0 means this edge resolves the last bit.
        if (bit_q[0]) begin
          out_data_d  = fits ? trial : root_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      root_q      <= '0;
      bit_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rad_q       <= rad_d;
      root_q      <= root_d;
      bit_q       <= bit_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sq.busy      = (state_q == CALC);
  assign sq.out_valid = out_valid_q;
  assign sq.out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_sqrt.sv
// Directed-vector bench for fixed_sqrt. Stimulus pushes {expected root,
// expected out_valid cycle} into a queue; an independent monitor pops and
// compares on every out_valid and checks out_data stays put otherwise.
module tb_fixed_sqrt;

  typedef struct {
    logic [14:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  fixed_sqrt_if sq ();

  fixed_sqrt dut (.clk(clk), .rst_n(rst_n), .sq(sq.slave));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic rst_seen = 1'b0;
  logic have_prev = 1'b0;
  logic [14:0] prev_out = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen = rst_n;
  end

  // Monitor
  always @(negedge clk) begin
    if (sq.out_valid) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got out_data=%h at cycle %0d, none expected", sq.out_data, cyc);
      end else begin
        e = sb.pop_front();
        if (sq.out_data !== e.data) begin
          errors++;
          $display("FAIL result: got out_data=%h expected %h", sq.out_data, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency: out_valid at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end else if (have_prev && rst_seen) begin
      checks++;
      if (sq.out_data !== prev_out) begin
        errors++;
        $display("FAIL out_hold: out_data=%h changed from %h without out_valid", sq.out_data, prev_out);
      end
    end
    prev_out  = sq.out_data;
    have_prev = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; acceptance is the next posedge,
  // result is seen at the negedge 15 cycles after that.
  task automatic go(input logic [19:0] d, input logic [14:0] r, input bit push);
    sq.in_valid = 1'b1;
    sq.in_data  = d;
    if (push) sb.push_back('{r, cyc + 16});
    @(negedge clk);
    sq.in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!sq.out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!sq.out_valid) check("wait_out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sq.busy || sq.out_valid) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (sq.busy || sq.out_valid) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    sq.in_valid = 1'b0;
    sq.in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, sq.busy}, 32'd0);
    check("reset_out_valid", {31'b0, sq.out_valid}, 32'd0);
    check("reset_out_data", {17'b0, sq.out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4.0 -> 2.0, busy exactly 15 cycles
    go(20'h01000, 15'h0800, 1'b1);
    n = 0;
    while (!sq.out_valid && n < 40) begin
      if (sq.busy) n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 32'd15);
    check("busy_low_at_out_valid", {31'b0, sq.busy}, 32'd0);
    wait_idle();

    go(20'h00800, 15'h05A8, 1'b1); wait_idle();
    go(20'h00100, 15'h0200, 1'b1); wait_idle();
    go(20'h00000, 15'h0000, 1'b1); wait_idle();
    go(20'hFFFFF, 15'h7FFF, 1'b1); wait_idle();
    go(20'h00400, 15'h0400, 1'b1); wait_idle();   // 1.0 -> 1.0
    go(20'h00001, 15'h0020, 1'b1); wait_idle();   // 2^-10 -> 2^-5

    // Back-to-back: second request in the out_valid cycle
    go(20'h01000, 15'h0800, 1'b1);
    wait_ov();
    go(20'h00800, 15'h05A8, 1'b1);
    wait_idle();

    // Mid-CALC in_valid with different data is ignored
    go(20'h00100, 15'h0200, 1'b1);
    repeat (4) @(negedge clk);
    sq.in_valid = 1'b1;
    sq.in_data  = 20'hFFFFF;
    repeat (3) @(negedge clk);
    sq.in_valid = 1'b0;
    wait_idle();

    // Reset at CALC cycle 7 aborts; in_valid during reset ignored
    go(20'h01000, 15'h0000, 1'b0);
    repeat (6) @(negedge clk);
    rst_n       = 1'b0;
    sq.in_valid = 1'b1;
    sq.in_data  = 20'h00800;
    @(negedge clk);
    check("abort_busy", {31'b0, sq.busy}, 32'd0);
    check("abort_out_valid", {31'b0, sq.out_valid}, 32'd0);
    check("abort_out_data", {17'b0, sq.out_data}, 32'd0);
    @(negedge clk);
    check("reset_hold_busy", {31'b0, sq.busy}, 32'd0);
    rst_n = 1'b1;
    sb.push_back('{15'h05A8, cyc + 16});
    @(negedge clk);
    sq.in_valid = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
